// File: rtl/rv_fetch_redirect.sv
// RV32 instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// in-order response buffering toward decode, and redirect with stale-response discard.
//
// state  | meaning
// RUN    | no stale responses outstanding; responses are buffered
// FLUSH  | drop_cnt responses from before the last redirect still to be discarded
module rv_fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        br_misalign
);

    localparam logic [2:0]  DEPTH_C  = 3'(DEPTH);
    localparam logic [1:0]  LAST_IDX = 2'(DEPTH - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] rsp_pc;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic [2:0]  out_cnt;
    logic [2:0]  buf_cnt;
    logic [2:0]  drop_cnt;
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [31:0] buf_pc    [4];
    logic [31:0] buf_instr [4];

    logic        req_hs;
    logic        rsp_take;
    logic        rsp_drop;
    logic        redirect;
    logic        push;
    logic        pop;
    logic [31:0] target_al;
    logic [2:0]  out_cnt_nxt;
    logic [2:0]  drop_cnt_nxt;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    assign imem_req_valid = ~rst & ((out_cnt + buf_cnt) < DEPTH_C);
    assign imem_req_addr  = pc;

    assign req_hs    = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding is spurious and leaves all state untouched.
    assign rsp_take  = imem_rsp_valid & (out_cnt != 3'd0);
    assign rsp_drop  = rsp_take & (state == ST_FLUSH);
    assign redirect  = br_valid & br_taken;
    assign target_al = {br_target[31:2], 2'b00};

    assign push = rsp_take & ~rsp_drop & ~redirect;
    assign pop  = if_valid & if_ready & ~redirect;

    assign out_cnt_nxt  = out_cnt + {2'b00, req_hs} - {2'b00, rsp_take};
    // Everything still in flight after this edge belongs to the old path, including a
    // request accepted in the redirect cycle itself.
    assign drop_cnt_nxt = redirect ? out_cnt_nxt : drop_cnt - {2'b00, rsp_drop};

    assign if_valid = (buf_cnt != 3'd0);
    assign if_pc    = if_valid ? buf_pc[head]    : last_pc;
    assign if_instr = if_valid ? buf_instr[head] : last_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            out_cnt     <= 3'd0;
            drop_cnt    <= 3'd0;
            buf_cnt     <= 3'd0;
            head        <= 2'd0;
            tail        <= 2'd0;
            last_pc     <= 32'h0000_0000;
            last_instr  <= NOP;
            br_misalign <= 1'b0;
        end else begin
            out_cnt     <= out_cnt_nxt;
            drop_cnt    <= drop_cnt_nxt;
            br_misalign <= redirect & (br_target[1:0] != 2'b00);

            case (state)
                ST_RUN:   state <= (drop_cnt_nxt != 3'd0) ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state <= (drop_cnt_nxt == 3'd0) ? ST_RUN : ST_FLUSH;
                default:  state <= ST_RUN;
            endcase

            if (redirect) begin
                pc <= target_al;
            end else if (req_hs) begin
                pc <= pc + 32'd4;
            end

            // Requests after a redirect are sequential from the target, so the PC of the
            // next kept response is tracked without storing per-request addresses.
            if (redirect) begin
                rsp_pc <= target_al;
            end else if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
            end

            if (if_valid) begin
                last_pc    <= buf_pc[head];
                last_instr <= buf_instr[head];
            end

            if (redirect) begin
                head    <= 2'd0;
                tail    <= 2'd0;
                buf_cnt <= 3'd0;
            end else begin
                if (push) begin
                    tail <= ptr_inc(tail);
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                buf_cnt <= buf_cnt + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail]    <= rsp_pc;
            buf_instr[tail] <= imem_rsp_data;
        end
    end

endmodule
